// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU with iterative multiply/divide.
//   - CTRL_W            : width of the MIPS funct operation code
//   - FN_*              : funct codes understood by alu_muldiv
//   - muldiv_state_e    : state encoding of the multiply/divide sequencer
//   - is_*_op helpers   : opcode classification used by top and datapath
package alu_pkg;

    localparam int CTRL_W = 6;

    localparam logic [CTRL_W-1:0] FN_SLL   = 6'b000000;
    localparam logic [CTRL_W-1:0] FN_SRL   = 6'b000010;
    localparam logic [CTRL_W-1:0] FN_SRA   = 6'b000011;
    localparam logic [CTRL_W-1:0] FN_MFHI  = 6'b010000;
    localparam logic [CTRL_W-1:0] FN_MTHI  = 6'b010001;
    localparam logic [CTRL_W-1:0] FN_MFLO  = 6'b010010;
    localparam logic [CTRL_W-1:0] FN_MTLO  = 6'b010011;
    localparam logic [CTRL_W-1:0] FN_MULT  = 6'b011000;
    localparam logic [CTRL_W-1:0] FN_MULTU = 6'b011001;
    localparam logic [CTRL_W-1:0] FN_DIV   = 6'b011010;
    localparam logic [CTRL_W-1:0] FN_DIVU  = 6'b011011;
    localparam logic [CTRL_W-1:0] FN_ADD   = 6'b100000;
    localparam logic [CTRL_W-1:0] FN_ADDU  = 6'b100001;
    localparam logic [CTRL_W-1:0] FN_SUB   = 6'b100010;
    localparam logic [CTRL_W-1:0] FN_SUBU  = 6'b100011;
    localparam logic [CTRL_W-1:0] FN_AND   = 6'b100100;
    localparam logic [CTRL_W-1:0] FN_OR    = 6'b100101;
    localparam logic [CTRL_W-1:0] FN_XOR   = 6'b100110;
    localparam logic [CTRL_W-1:0] FN_NOR   = 6'b100111;
    localparam logic [CTRL_W-1:0] FN_SLT   = 6'b101010;
    localparam logic [CTRL_W-1:0] FN_SLTU  = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } muldiv_state_e;

    function automatic logic is_muldiv_op(input logic [CTRL_W-1:0] code);
        return (code == FN_MULT) || (code == FN_MULTU) ||
               (code == FN_DIV)  || (code == FN_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [CTRL_W-1:0] code);
        return (code == FN_DIV) || (code == FN_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [CTRL_W-1:0] code);
        return (code == FN_MULT) || (code == FN_DIV);
    endfunction

    // Operations that touch HI/LO or the engine and so must wait while it runs.
    function automatic logic is_hilo_op(input logic [CTRL_W-1:0] code);
        return is_muldiv_op(code) ||
               (code == FN_MFHI) || (code == FN_MFLO) ||
               (code == FN_MTHI) || (code == FN_MTLO);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle multiply (shift-add) / divide (restoring)
// datapath working on operand magnitudes, with sign fix-up of the result.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : latch op/a/b and clear the iteration counter
//   step           : perform one iteration
//   op, a, b       : operation code and operands (sampled on start)
//   last           : current iteration is the final one
//   res_hi, res_lo : signed-corrected result after the current iteration
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int NB = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              step,
    input  logic [CTRL_W-1:0] op,
    input  logic [NB-1:0]     a,
    input  logic [NB-1:0]     b,
    output logic              last,
    output logic [NB-1:0]     res_hi,
    output logic [NB-1:0]     res_lo
);

    localparam int CW = $clog2(NB);

    // acc_r = {upper, lower}: product accumulator / {remainder, quotient}
    logic [2*NB-1:0] acc_r;
    logic [2*NB-1:0] acc_next_s;
    logic [2*NB-1:0] prod_s;
    logic [NB-1:0]   opnd_r;
    logic            div_r;
    logic            lo_neg_r;
    logic            hi_neg_r;
    logic [CW-1:0]   cnt_r;

    logic            a_neg_s;
    logic            b_neg_s;
    logic [NB-1:0]   a_mag_s;
    logic [NB-1:0]   b_mag_s;
    logic [NB:0]     sum_s;
    logic [NB:0]     shifted_s;
    logic [NB:0]     trial_s;

    assign a_neg_s = is_signed_op(op) & a[NB-1];
    assign b_neg_s = is_signed_op(op) & b[NB-1];
    // The most-negative value maps onto 2^(NB-1), which still fits unsigned.
    assign a_mag_s = a_neg_s ? -a : a;
    assign b_mag_s = b_neg_s ? -b : b;

    // Multiply: add multiplicand into the upper half when the LSB is set.
    assign sum_s     = {1'b0, acc_r[2*NB-1:NB]} + ({1'b0, opnd_r} & {(NB+1){acc_r[0]}});
    // Divide: shift the next dividend bit into the partial remainder, try subtract.
    assign shifted_s = acc_r[2*NB-1:NB-1];
    assign trial_s   = shifted_s - {1'b0, opnd_r};

    assign last = (cnt_r == CW'(NB-1));

    // One iteration of the selected algorithm.
    always_comb begin
        acc_next_s = acc_r;
        if (div_r) begin
            if (!trial_s[NB]) begin
                acc_next_s = {trial_s[NB-1:0], acc_r[NB-2:0], 1'b1};
            end else begin
                acc_next_s = {shifted_s[NB-1:0], acc_r[NB-2:0], 1'b0};
            end
        end else begin
            acc_next_s = {sum_s, acc_r[NB-1:1]};
        end
    end

    // Sign fix-up applied to the post-iteration value so the final edge can commit it.
    always_comb begin
        prod_s = lo_neg_r ? -acc_next_s : acc_next_s;
        if (div_r) begin
            res_lo = lo_neg_r ? -acc_next_s[NB-1:0]      : acc_next_s[NB-1:0];
            res_hi = hi_neg_r ? -acc_next_s[2*NB-1:NB]   : acc_next_s[2*NB-1:NB];
        end else begin
            res_lo = prod_s[NB-1:0];
            res_hi = prod_s[2*NB-1:NB];
        end
    end

    // Operand capture on start, accumulate and count on each step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r    <= '0;
            opnd_r   <= '0;
            div_r    <= 1'b0;
            lo_neg_r <= 1'b0;
            hi_neg_r <= 1'b0;
            cnt_r    <= '0;
        end else if (start) begin
            div_r    <= is_div_op(op);
            lo_neg_r <= a_neg_s ^ b_neg_s;
            hi_neg_r <= is_div_op(op) ? a_neg_s : (a_neg_s ^ b_neg_s);
            cnt_r    <= '0;
            if (is_div_op(op)) begin
                acc_r  <= {{NB{1'b0}}, a_mag_s};
                opnd_r <= b_mag_s;
            end else begin
                acc_r  <= {{NB{1'b0}}, b_mag_s};
                opnd_r <= a_mag_s;
            end
        end else if (step) begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: MIPS-style ALU with combinational ops and an iterative
// multiply/divide engine writing the HI/LO register pair.
//   i_clk, i_rst_n              : clock, asynchronous active-low reset
//   i_valid                     : operation valid this cycle
//   i_alu_control               : funct code
//   i_alu_input_A/B             : operands (A holds the shift amount)
//   o_alu_result                : combinational result
//   o_alu_condition_zero        : result equals zero
//   o_overflow                  : signed overflow of ADD/SUB
//   o_busy / o_stall            : engine active / hold the issuing stage
//   o_done / o_div_by_zero      : HI/LO update pulse / divide-by-zero qualifier
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int NB_INPUT   = 32,
    parameter int NB_CONTROL = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic [NB_CONTROL-1:0] i_alu_control,
    input  logic [NB_INPUT-1:0]   i_alu_input_A,
    input  logic [NB_INPUT-1:0]   i_alu_input_B,
    output logic [NB_INPUT-1:0]   o_alu_result,
    output logic                  o_alu_condition_zero,
    output logic                  o_overflow,
    output logic                  o_busy,
    output logic                  o_stall,
    output logic                  o_done,
    output logic                  o_div_by_zero
);

    localparam int SHW = $clog2(NB_INPUT);
    localparam int MSB = NB_INPUT - 1;

    muldiv_state_e         state_r;
    muldiv_state_e         state_next_s;
    logic [NB_INPUT-1:0]   hi_r;
    logic [NB_INPUT-1:0]   lo_r;
    logic                  dbz_r;

    logic                  start_s;
    logic                  last_s;
    logic                  mt_ok_s;
    logic [NB_INPUT-1:0]   res_hi_s;
    logic [NB_INPUT-1:0]   res_lo_s;
    logic [SHW-1:0]        shamt_s;
    logic [NB_INPUT-1:0]   sum_s;
    logic [NB_INPUT-1:0]   diff_s;
    logic [NB_INPUT-1:0]   result_s;
    logic                  ovf_s;

    assign start_s = i_valid && (state_r == ST_IDLE) && is_muldiv_op(i_alu_control);
    assign mt_ok_s = i_valid && (state_r == ST_IDLE);
    assign shamt_s = i_alu_input_A[SHW-1:0];
    assign sum_s   = i_alu_input_A + i_alu_input_B;
    assign diff_s  = i_alu_input_A - i_alu_input_B;

    muldiv_iter #(
        .NB (NB_INPUT)
    ) u_iter (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .start  (start_s),
        .step   (state_r == ST_BUSY),
        .op     (i_alu_control),
        .a      (i_alu_input_A),
        .b      (i_alu_input_B),
        .last   (last_s),
        .res_hi (res_hi_s),
        .res_lo (res_lo_s)
    );

    // Combinational ALU result and signed overflow.
    always_comb begin
        result_s = '0;
        ovf_s    = 1'b0;
        case (i_alu_control)
            FN_ADD: begin
                result_s = sum_s;
                ovf_s    = (i_alu_input_A[MSB] == i_alu_input_B[MSB]) && (sum_s[MSB] != i_alu_input_A[MSB]);
            end
            FN_ADDU: result_s = sum_s;
            FN_SUB: begin
                result_s = diff_s;
                ovf_s    = (i_alu_input_A[MSB] != i_alu_input_B[MSB]) && (diff_s[MSB] != i_alu_input_A[MSB]);
            end
            FN_SUBU: result_s = diff_s;
            FN_AND:  result_s = i_alu_input_A & i_alu_input_B;
            FN_OR:   result_s = i_alu_input_A | i_alu_input_B;
            FN_XOR:  result_s = i_alu_input_A ^ i_alu_input_B;
            FN_NOR:  result_s = ~(i_alu_input_A | i_alu_input_B);
            FN_SLL:  result_s = i_alu_input_B << shamt_s;
            FN_SRL:  result_s = i_alu_input_B >> shamt_s;
            FN_SRA:  result_s = $signed(i_alu_input_B) >>> shamt_s;
            FN_SLT:  result_s = {{(NB_INPUT-1){1'b0}}, ($signed(i_alu_input_A) < $signed(i_alu_input_B))};
            FN_SLTU: result_s = {{(NB_INPUT-1){1'b0}}, (i_alu_input_A < i_alu_input_B)};
            FN_MFHI: result_s = hi_r;
            FN_MFLO: result_s = lo_r;
            default: begin
                result_s = '0;
                ovf_s    = 1'b0;
            end
        endcase
    end

    // Sequencer next state: NB_INPUT busy iterations, then one done cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Divide-by-zero is decided from the operands captured at start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dbz_r <= 1'b0;
        end else if (start_s) begin
            dbz_r <= is_div_op(i_alu_control) && (i_alu_input_B == '0);
        end
    end

    // HI/LO: engine result on the final iteration, otherwise MTHI/MTLO when idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if ((state_r == ST_BUSY) && last_s) begin
            if (!dbz_r) begin
                hi_r <= res_hi_s;
                lo_r <= res_lo_s;
            end
        end else if (mt_ok_s && (i_alu_control == FN_MTHI)) begin
            hi_r <= i_alu_input_A;
        end else if (mt_ok_s && (i_alu_control == FN_MTLO)) begin
            lo_r <= i_alu_input_A;
        end
    end

    assign o_alu_result         = result_s;
    assign o_alu_condition_zero = (result_s == '0);
    assign o_overflow           = ovf_s;
    assign o_busy               = (state_r != ST_IDLE);
    assign o_stall              = o_busy && i_valid && is_hilo_op(i_alu_control);
    assign o_done               = (state_r == ST_DONE);
    assign o_div_by_zero        = (state_r == ST_DONE) && dbz_r;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: an arithmetic reference model (64-bit
// products, native signed division, cycle counter for the engine timeline)
// checked every cycle, plus directed literal expectations and random traffic.
module tb_alu_muldiv;

    localparam logic [5:0] C_SLL = 6'b000000, C_SRL = 6'b000010, C_SRA = 6'b000011;
    localparam logic [5:0] C_MFHI = 6'b010000, C_MTHI = 6'b010001, C_MFLO = 6'b010010, C_MTLO = 6'b010011;
    localparam logic [5:0] C_MULT = 6'b011000, C_MULTU = 6'b011001, C_DIV = 6'b011010, C_DIVU = 6'b011011;
    localparam logic [5:0] C_ADD = 6'b100000, C_ADDU = 6'b100001, C_SUB = 6'b100010, C_SUBU = 6'b100011;
    localparam logic [5:0] C_AND = 6'b100100, C_OR = 6'b100101, C_XOR = 6'b100110, C_NOR = 6'b100111;
    localparam logic [5:0] C_SLT = 6'b101010, C_SLTU = 6'b101011;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [5:0]  ctrl = 6'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] o_alu_result;
    logic        o_alu_condition_zero, o_overflow, o_busy, o_stall, o_done, o_div_by_zero;

    int n_tests = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    // Reference model state
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
    bit          p_dbz = 1'b0;
    int          m_cnt = 0;   // 0 idle, 1..32 busy iterations, 33 done cycle

    logic [5:0] codes [21] = '{C_ADD, C_ADDU, C_SUB, C_SUBU, C_AND, C_OR, C_XOR, C_NOR, C_SLL, C_SRL,
                               C_SRA, C_SLT, C_SLTU, C_MFHI, C_MFLO, C_MTHI, C_MTLO, C_MULT, C_MULTU,
                               C_DIV, C_DIVU};

    alu_muldiv #(.NB_INPUT(32), .NB_CONTROL(6)) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_valid              (valid),
        .i_alu_control        (ctrl),
        .i_alu_input_A        (a),
        .i_alu_input_B        (b),
        .o_alu_result         (o_alu_result),
        .o_alu_condition_zero (o_alu_condition_zero),
        .o_overflow           (o_overflow),
        .o_busy               (o_busy),
        .o_stall              (o_stall),
        .o_done               (o_done),
        .o_div_by_zero        (o_div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_seq(input logic [5:0] c);
        return (c == C_MULT) || (c == C_MULTU) || (c == C_DIV) || (c == C_DIVU) ||
               (c == C_MFHI) || (c == C_MFLO) || (c == C_MTHI) || (c == C_MTLO);
    endfunction

    function automatic void alu_ref(input logic [5:0] c, input logic [31:0] x, input logic [31:0] y,
                                    input logic [31:0] hi, input logic [31:0] lo,
                                    output logic [31:0] r, output logic v);
        longint sx, sy, s;
        int sh;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sh = int'(x[4:0]);
        r = 32'd0;
        v = 1'b0;
        case (c)
            C_ADD:  begin s = sx + sy; r = s[31:0]; v = (s > MAXS) || (s < MINS); end
            C_ADDU: r = x + y;
            C_SUB:  begin s = sx - sy; r = s[31:0]; v = (s > MAXS) || (s < MINS); end
            C_SUBU: r = x - y;
            C_AND:  r = x & y;
            C_OR:   r = x | y;
            C_XOR:  r = x ^ y;
            C_NOR:  r = ~(x | y);
            C_SLL:  r = y << sh;
            C_SRL:  r = y >> sh;
            C_SRA:  begin s = sy >>> sh; r = s[31:0]; end
            C_SLT:  r = (sx < sy) ? 32'd1 : 32'd0;
            C_SLTU: r = (x < y) ? 32'd1 : 32'd0;
            C_MFHI: r = hi;
            C_MFLO: r = lo;
            default: r = 32'd0;
        endcase
    endfunction

    function automatic void muldiv_ref(input logic [5:0] c, input logic [31:0] x, input logic [31:0] y,
                                       output logic [31:0] hi, output logic [31:0] lo, output bit dz);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p = 64'd0;
        dz = 1'b0;
        case (c)
            C_MULT:  begin q = sx * sy; p = q; end
            C_MULTU: p = {32'd0, x} * {32'd0, y};
            C_DIV: begin
                if (y == 32'd0) dz = 1'b1;
                else begin q = sx / sy; r = sx % sy; p = {r[31:0], q[31:0]}; end
            end
            C_DIVU: begin
                if (y == 32'd0) dz = 1'b1;
                else p = {x % y, x / y};
            end
            default: p = 64'd0;
        endcase
        hi = p[63:32];
        lo = p[31:0];
    endfunction

    // Reference timeline: start, 32 iterations, HI/LO commit into the done cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_hi = 32'd0; m_lo = 32'd0; p_dbz = 1'b0;
        end else if (m_cnt == 0) begin
            if (valid && (ctrl == C_MULT || ctrl == C_MULTU || ctrl == C_DIV || ctrl == C_DIVU)) begin
                muldiv_ref(ctrl, a, b, p_hi, p_lo, p_dbz);
                m_cnt = 1;
            end else if (valid && ctrl == C_MTHI) m_hi = a;
            else if (valid && ctrl == C_MTLO) m_lo = a;
        end else if (m_cnt == 32) begin
            if (!p_dbz) begin m_hi = p_hi; m_lo = p_lo; end
            m_cnt = 33;
        end else if (m_cnt == 33) begin
            m_cnt = 0;
        end else begin
            m_cnt = m_cnt + 1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (checking) begin
            logic [31:0] er;
            logic ev;
            bit eb;
            alu_ref(ctrl, a, b, m_hi, m_lo, er, ev);
            eb = (m_cnt != 0);
            chk32("result", o_alu_result, er);
            chk1("zero", o_alu_condition_zero, er == 32'd0);
            chk1("overflow", o_overflow, ev);
            chk1("busy", o_busy, eb);
            chk1("stall", o_stall, eb && valid && is_seq(ctrl));
            chk1("done", o_done, m_cnt == 33);
            chk1("div_by_zero", o_div_by_zero, (m_cnt == 33) && p_dbz);
        end
    end

    task automatic set_in(input logic v, input logic [5:0] c, input logic [31:0] x, input logic [31:0] y);
        valid = v; ctrl = c; a = x; b = y;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [5:0] c, input logic [31:0] exp, input string nm);
        set_in(1'b0, c, 32'd0, 32'd0);
        #1;
        chk32(nm, o_alu_result, exp);
    endtask

    // Issue an engine op; returns the cycle index (issue cycle = 0) of o_done, or -1.
    task automatic run_op(input logic [5:0] c, input logic [31:0] x, input logic [31:0] y, output int dcyc);
        set_in(1'b1, c, x, y);
        next_cyc();
        set_in(1'b0, C_ADD, 32'd0, 32'd0);
        dcyc = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (o_done) begin
                dcyc = i;
                break;
            end
            next_cyc();
        end
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int rel;
        set_in(1'b0, C_ADD, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_busy", o_busy, 1'b0);
        chk1("rst_done", o_done, 1'b0);
        peek(C_MFHI, 32'd0, "rst_hi");
        peek(C_MFLO, 32'd0, "rst_lo");
        checking = 1'b1;
        rst_n = 1'b1;
        next_cyc();

        // Signed vs unsigned add overflow
        set_in(1'b1, C_ADD, 32'h7FFF_FFFF, 32'd1);
        #1;
        chk32("add_res", o_alu_result, 32'h8000_0000);
        chk1("add_ovf", o_overflow, 1'b1);
        set_in(1'b1, C_ADDU, 32'h7FFF_FFFF, 32'd1);
        #1;
        chk32("addu_res", o_alu_result, 32'h8000_0000);
        chk1("addu_ovf", o_overflow, 1'b0);
        next_cyc();

        run_op(C_MULT, 32'hFFFF_FFFE, 32'd3, d);
        chk32("mult_latency", d, 32'd33);
        next_cyc();
        peek(C_MFHI, 32'hFFFF_FFFF, "mult_hi");
        peek(C_MFLO, 32'hFFFF_FFFA, "mult_lo");

        run_op(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, d);
        next_cyc();
        peek(C_MFHI, 32'hFFFF_FFFE, "multu_hi");
        peek(C_MFLO, 32'd1, "multu_lo");

        run_op(C_DIV, 32'hFFFF_FFF9, 32'd2, d);
        next_cyc();
        peek(C_MFHI, 32'hFFFF_FFFF, "div_hi");
        peek(C_MFLO, 32'hFFFF_FFFD, "div_lo");

        run_op(C_DIVU, 32'd100, 32'd0, d);
        chk1("divu0_flag", o_div_by_zero, 1'b1);
        next_cyc();
        peek(C_MFHI, 32'hFFFF_FFFF, "divu0_hi");
        peek(C_MFLO, 32'hFFFF_FFFD, "divu0_lo");

        run_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, d);
        chk1("divmin_flag", o_div_by_zero, 1'b0);
        next_cyc();
        peek(C_MFHI, 32'd0, "divmin_hi");
        peek(C_MFLO, 32'h8000_0000, "divmin_lo");

        // MFLO 5 cycles after MULT stalls until the engine is idle; ADD flows through.
        set_in(1'b1, C_MULT, 32'd5, 32'd7);
        next_cyc();
        set_in(1'b0, C_ADD, 32'd0, 32'd0);
        repeat (4) next_cyc();
        set_in(1'b1, C_ADD, 32'd2, 32'd3);
        #1;
        chk1("add_no_stall", o_stall, 1'b0);
        chk32("add_in_busy", o_alu_result, 32'd5);
        next_cyc();
        set_in(1'b1, C_MFLO, 32'd0, 32'd0);
        rel = -1;
        for (int i = 6; i <= 45; i++) begin
            @(negedge clk);
            if (!o_stall) begin
                rel = i;
                break;
            end
            next_cyc();
        end
        chk32("mflo_release", rel, 32'd34);
        chk32("mflo_value", o_alu_result, 32'd35);
        next_cyc();

        // Reset in the middle of a divide.
        set_in(1'b1, C_DIVU, 32'd1000, 32'd7);
        next_cyc();
        set_in(1'b0, C_ADD, 32'd0, 32'd0);
        repeat (10) next_cyc();
        rst_n = 1'b0;
        #1;
        chk1("abort_busy", o_busy, 1'b0);
        peek(C_MFHI, 32'd0, "abort_hi");
        peek(C_MFLO, 32'd0, "abort_lo");
        next_cyc();
        rst_n = 1'b1;

        // Start accepted on the first edge after reset; MTHI while busy is ignored.
        set_in(1'b1, C_MULT, 32'd6, 32'd7);
        next_cyc();
        chk1("start_after_rst", o_busy, 1'b1);
        set_in(1'b1, C_MTHI, 32'h0000_BEEF, 32'd0);
        #1;
        chk1("mthi_stall", o_stall, 1'b1);
        next_cyc();
        set_in(1'b1, C_MFHI, 32'd0, 32'd0);
        #1;
        chk32("mthi_ignored", o_alu_result, 32'd0);
        rel = -1;
        for (int i = 0; i < 40; i++) begin
            next_cyc();
            if (!o_busy) begin
                rel = i;
                break;
            end
        end
        chk1("idle_timeout", rel >= 0, 1'b1);
        set_in(1'b1, C_MTHI, 32'h0000_1234, 32'd0);
        next_cyc();
        peek(C_MFHI, 32'h0000_1234, "mthi_mfhi");
        peek(C_MFLO, 32'd42, "mult67_lo");
        next_cyc();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] c;
            int k;
            k = $urandom_range(0, 27);
            if (k < 21) c = codes[k];
            else c = 6'($urandom);
            set_in(1'($urandom_range(0, 1)), c, rnd_opnd(), rnd_opnd());
            if ((i % 700) == 699) begin
                rst_n = 1'b0;
                next_cyc();
                rst_n = 1'b1;
            end else begin
                next_cyc();
            end
        end
        set_in(1'b0, C_ADD, 32'd0, 32'd0);
        repeat (40) next_cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
